// File: rtl/cpu_codes_pkg.sv
// Control codes shared by the controller and the X/Y/Z datapath, plus the
// register-code decoder that each register applies to its own code.
package cpu_codes_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [CODE_W-1:0] {
    REG_CLEAR  = 4'd0,
    REG_LOAD   = 4'd1,
    REG_HOLD   = 4'd2,
    REG_SHIFTR = 4'd3
  } reg_code_e;

  typedef enum logic [CODE_W-1:0] {
    ULA_ADD   = 4'd0,
    ULA_SUB   = 4'd1,
    ULA_AND   = 4'd2,
    ULA_OR    = 4'd3,
    ULA_XOR   = 4'd4,
    ULA_NOTX  = 4'd5,
    ULA_PASSX = 4'd6,
    ULA_PASSY = 4'd7
  } ula_code_e;

  // One-hot register action; an all-zero action means HOLD.
  typedef struct packed {
    logic clr;
    logic ld;
    logic shr;
    logic bad;
  } reg_ctl_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '{zero: 1'b1, carry: 1'b0, ovf: 1'b0};

  // Undefined codes behave as HOLD but are reported as illegal.
  function automatic reg_ctl_t decode_reg(input logic [CODE_W-1:0] code);
    reg_ctl_t ctl;
    ctl = '0;
    case (code)
      REG_CLEAR:  ctl.clr = 1'b1;
      REG_LOAD:   ctl.ld  = 1'b1;
      REG_HOLD:   ;
      REG_SHIFTR: ctl.shr = 1'b1;
      default:    ctl.bad = 1'b1;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/datapath_xyz_if.sv
// Controller-to-datapath bus: operand and per-cycle codes in, register
// values and status flags out.
interface datapath_xyz_if
  import cpu_codes_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]  data_in;
  logic [CODE_W-1:0] tx;
  logic [CODE_W-1:0] ty;
  logic [CODE_W-1:0] tz;
  logic [CODE_W-1:0] tula;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic [WIDTH-1:0]  z;
  logic              flag_zero;
  logic              flag_carry;
  logic              flag_ovf;
  logic              illegal;

  modport master (
    output data_in, tx, ty, tz, tula,
    input  x, y, z, flag_zero, flag_carry, flag_ovf, illegal
  );

  modport slave (
    input  data_in, tx, ty, tz, tula,
    output x, y, z, flag_zero, flag_carry, flag_ovf, illegal
  );
endinterface

// File: rtl/ula_core.sv
// Combinational ALU: eight operations on a and b with unsigned carry/borrow
// and signed overflow for ADD/SUB.
module ula_core
  import cpu_codes_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CODE_W-1:0] op,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              ovf,
  output logic              op_illegal
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    sum_w      = {1'b0, a} + {1'b0, b};
    diff_w     = {1'b0, a} - {1'b0, b};
    result     = '0;
    carry      = 1'b0;
    ovf        = 1'b0;
    op_illegal = 1'b0;
    case (op)
      ULA_ADD: begin
        result = sum_w[MSB:0];
        carry  = sum_w[WIDTH];
        ovf    = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      // Extra top bit of the difference is the unsigned borrow (a < b).
      ULA_SUB: begin
        result = diff_w[MSB:0];
        carry  = diff_w[WIDTH];
        ovf    = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
      end
      ULA_AND:   result = a & b;
      ULA_OR:    result = a | b;
      ULA_XOR:   result = a ^ b;
      ULA_NOTX:  result = ~a;
      ULA_PASSX: result = a;
      ULA_PASSY: result = b;
      default:   op_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/datapath_xyz.sv
// X/Y/Z register datapath: each register follows its own code every cycle,
// Z loads from the ALU, flags and the illegal pulse are registered.
module datapath_xyz
  import cpu_codes_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic          clock,
  input logic          reset,
  datapath_xyz_if.slave bus
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  flags_t           flags_q, flags_d;
  logic             illegal_q, illegal_d;

  reg_ctl_t         ctl_x, ctl_y, ctl_z;
  logic [WIDTH-1:0] ula_res;
  logic             ula_carry, ula_ovf, ula_bad;

  ula_core #(.WIDTH(WIDTH)) u_ula (
    .a          (x_q),
    .b          (y_q),
    .op         (bus.tula),
    .result     (ula_res),
    .carry      (ula_carry),
    .ovf        (ula_ovf),
    .op_illegal (ula_bad)
  );

  function automatic logic [WIDTH-1:0] next_reg(input reg_ctl_t ctl,
                                                input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] src);
    if (ctl.clr) return '0;
    if (ctl.ld)  return src;
    if (ctl.shr) return cur >> 1;
    return cur;
  endfunction

  // Every source is a pre-edge register value, so X->Y forms a shift chain.
  always_comb begin
    ctl_x = decode_reg(bus.tx);
    ctl_y = decode_reg(bus.ty);
    ctl_z = decode_reg(bus.tz);

    x_d = next_reg(ctl_x, x_q, bus.data_in);
    y_d = next_reg(ctl_y, y_q, x_q);
    z_d = next_reg(ctl_z, z_q, ula_res);

    flags_d = flags_q;
    if (ctl_z.ld) begin
      flags_d.zero  = (ula_res == '0);
      flags_d.carry = ula_carry;
      flags_d.ovf   = ula_ovf;
    end else if (ctl_z.clr) begin
      flags_d = FLAGS_CLEAR;
    end

    // tula only matters when Z actually loads from the ALU.
    illegal_d = ctl_x.bad | ctl_y.bad | ctl_z.bad | (ctl_z.ld & ula_bad);
  end

  // NOTE: state registers use non-blocking assignments so all of them sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      flags_q   <= FLAGS_CLEAR;
      illegal_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      z_q       <= z_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.z          = z_q;
  assign bus.flag_zero  = flags_q.zero;
  assign bus.flag_carry = flags_q.carry;
  assign bus.flag_ovf   = flags_q.ovf;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_datapath_xyz.sv
// Self-checking bench for datapath_xyz: directed vector table, random codes
// against an integer reference model, and an asynchronous reset mid-loop.
module tb_datapath_xyz;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int C = 0, L = 1, H = 2, S = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datapath_xyz_if #(.WIDTH(W)) bus ();
  datapath_xyz #(.WIDTH(W)) dut (.clock(clk), .reset(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state (plain integers).
  int mx, my, mz, mzero, mc, mo, mill;

  typedef struct {
    int d, tx, ty, tz, tula;
    int ex, ey, ez, ezero, ec, eo, eill;
  } vec_t;

  vec_t tbl[27];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sg(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  function automatic int apply(input int code, input int cur, input int src);
    case (code)
      0:       return 0;
      1:       return src;
      3:       return cur / 2;
      default: return cur;
    endcase
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mz = 0; mzero = 1; mc = 0; mo = 0; mill = 0;
  endtask

  task automatic model_step(input int d, input int tx, input int ty,
                            input int tz, input int tula);
    int r, c, o, s;
    r = 0; c = 0; o = 0;
    case (tula)
      0: begin s = mx + my; r = s & MASK; c = (s > MASK);
               s = sg(mx) + sg(my); o = (s > MASK / 2) || (s < -(MASK / 2) - 1); end
      1: begin r = (mx - my) & MASK; c = (mx < my);
               s = sg(mx) - sg(my); o = (s > MASK / 2) || (s < -(MASK / 2) - 1); end
      2: r = mx & my;
      3: r = mx | my;
      4: r = mx ^ my;
      5: r = MASK - mx;
      6: r = mx;
      7: r = my;
      default: r = 0;
    endcase
    mill = (tx > 3) || (ty > 3) || (tz > 3) || (tz == 1 && tula > 7);
    if (tz == 1) begin mzero = (r == 0); mc = c; mo = o; end
    else if (tz == 0) begin mzero = 1; mc = 0; mo = 0; end
    {mx, my, mz} = {apply(tx, mx, d & MASK), apply(ty, my, mx), apply(tz, mz, r)};
  endtask

  task automatic step(input int d, input int tx, input int ty,
                      input int tz, input int tula);
    bus.data_in = d[W-1:0];
    bus.tx = tx[3:0]; bus.ty = ty[3:0]; bus.tz = tz[3:0]; bus.tula = tula[3:0];
    model_step(d, tx, ty, tz, tula);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".x"}, bus.x, mx);
    check({tag, ".y"}, bus.y, my);
    check({tag, ".z"}, bus.z, mz);
    check({tag, ".zero"}, bus.flag_zero, mzero);
    check({tag, ".carry"}, bus.flag_carry, mc);
    check({tag, ".ovf"}, bus.flag_ovf, mo);
    check({tag, ".illegal"}, bus.illegal, mill);
  endtask

  function automatic int rnd_reg();
    return ($urandom_range(0, 9) < 9) ? $urandom_range(0, 3) : $urandom_range(4, 15);
  endfunction

  initial begin
    //           d  tx ty tz tula |  x   y   z  zr c  o  il
    tbl[0]  = '{ 0, H, H, H, 0,     0,  0,  0, 1, 0, 0, 0};
    tbl[1]  = '{ 5, L, H, H, 0,     5,  0,  0, 1, 0, 0, 0};
    tbl[2]  = '{ 3, L, L, H, 0,     3,  5,  0, 1, 0, 0, 0};
    tbl[3]  = '{ 0, H, H, L, 0,     3,  5,  8, 0, 0, 1, 0};
    tbl[4]  = '{ 0, H, H, L, 1,     3,  5, 14, 0, 1, 0, 0};
    tbl[5]  = '{ 0, 7, H, H, 0,     3,  5, 14, 0, 1, 0, 1};
    tbl[6]  = '{ 0, H, H, H, 12,    3,  5, 14, 0, 1, 0, 0};
    tbl[7]  = '{ 0, H, H, L, 12,    3,  5,  0, 1, 0, 0, 1};
    tbl[8]  = '{ 0, H, S, C, 0,     3,  2,  0, 1, 0, 0, 0};
    tbl[9]  = '{ 0, C, S, H, 0,     0,  1,  0, 1, 0, 0, 0};
    tbl[10] = '{15, L, C, H, 0,    15,  0,  0, 1, 0, 0, 0};
    tbl[11] = '{ 0, H, L, H, 0,    15, 15,  0, 1, 0, 0, 0};
    tbl[12] = '{ 0, H, H, L, 0,    15, 15, 14, 0, 1, 0, 0};
    tbl[13] = '{ 0, H, H, S, 0,    15, 15,  7, 0, 1, 0, 0};
    tbl[14] = '{ 0, H, H, L, 4,    15, 15,  0, 1, 0, 0, 0};
    tbl[15] = '{ 6, L, H, L, 5,     6, 15,  0, 1, 0, 0, 0};
    tbl[16] = '{ 0, H, 9, L, 6,     6, 15,  6, 0, 0, 0, 1};
    tbl[17] = '{ 0, H, H, L, 2,     6, 15,  6, 0, 0, 0, 0};
    tbl[18] = '{ 0, H, H, L, 3,     6, 15, 15, 0, 0, 0, 0};
    tbl[19] = '{ 0, H, H, L, 7,     6, 15, 15, 0, 0, 0, 0};
    tbl[20] = '{ 0, H, H, L, 1,     6, 15,  7, 0, 1, 0, 0};
    tbl[21] = '{ 9, L, H, H, 0,     9, 15,  7, 0, 1, 0, 0};
    tbl[22] = '{ 0, H, L, H, 0,     9,  9,  7, 0, 1, 0, 0};
    tbl[23] = '{ 0, H, S, H, 0,     9,  4,  7, 0, 1, 0, 0};
    tbl[24] = '{ 0, H, S, H, 0,     9,  2,  7, 0, 1, 0, 0};
    tbl[25] = '{ 0, H, H, 15, 0,    9,  2,  7, 0, 1, 0, 1};
    tbl[26] = '{ 0, H, H, L, 1,     9,  2,  7, 0, 0, 1, 0};

    // Reset state, checked while reset is held.
    rst = 1'b1;
    bus.data_in = '0; bus.tx = 4'd2; bus.ty = 4'd2; bus.tz = 4'd2; bus.tula = 4'd0;
    model_reset();
    #12;
    check_model("reset");
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(0, H, H, H, 0);
      check_model($sformatf("idle%0d", i));
    end

    for (int i = 0; i < 27; i++) begin
      step(tbl[i].d, tbl[i].tx, tbl[i].ty, tbl[i].tz, tbl[i].tula);
      check($sformatf("vec%0d.x", i), bus.x, tbl[i].ex);
      check($sformatf("vec%0d.y", i), bus.y, tbl[i].ey);
      check($sformatf("vec%0d.z", i), bus.z, tbl[i].ez);
      check($sformatf("vec%0d.zero", i), bus.flag_zero, tbl[i].ezero);
      check($sformatf("vec%0d.carry", i), bus.flag_carry, tbl[i].ec);
      check($sformatf("vec%0d.ovf", i), bus.flag_ovf, tbl[i].eo);
      check($sformatf("vec%0d.illegal", i), bus.illegal, tbl[i].eill);
    end

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, MASK), rnd_reg(), rnd_reg(), rnd_reg(),
           ($urandom_range(0, 8) < 8) ? $urandom_range(0, 7) : $urandom_range(8, 15));
      check_model($sformatf("rnd%0d", i));
    end

    // Controller loop interrupted by an asynchronous reset between edges.
    step(5, L, H, H, 0);
    step(12, L, L, H, 0);
    step(0, H, L, H, 0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_model("async_rst");
    #2 rst = 1'b0;

    // Full loop after release: z = ADD(12, 12>>1) = 18 mod 16 = 2, carry out.
    step(5, L, H, H, 0);
    step(12, L, L, H, 0);
    step(0, H, L, H, 0);
    step(0, H, S, H, 0);
    step(0, H, H, L, 0);
    check("loop.z", bus.z, 2);
    check("loop.carry", bus.flag_carry, 1);
    check_model("loop");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
